// File: rtl/mem_arbiter_pkg.sv
// +-----------------------------------------------------------------------------+
// | mem_arbiter_pkg : shared arbiter state encoding, port ids and DQM codes     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    RR         = 2'd0,
    LOCK1_PEND = 2'd1,
    LOCK1      = 2'd2
  } arb_state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  // Size codes understood by the control unit and the data memory.
  localparam int               DQM_WIDTH = 2;
  localparam logic [DQM_WIDTH-1:0] DQM_BYTE = 2'b00;
  localparam logic [DQM_WIDTH-1:0] DQM_HALF = 2'b01;
  localparam logic [DQM_WIDTH-1:0] DQM_WORD = 2'b10;

  function automatic logic other_port(input logic port);
    return ~port;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// +-----------------------------------------------------------------------------+
// | mem_arbiter_if : requester ports 0/1 plus the shared memory port            |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DQM_W  = mem_arbiter_pkg::DQM_WIDTH
) ();

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic [DQM_W-1:0]  dqm0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic [DQM_W-1:0]  dqm1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;
  logic              lock1;

  logic [ADDR_W-1:0] memAddr;
  logic              memWe;
  logic [DATA_W-1:0] memWdata;
  logic [DQM_W-1:0]  memDQM;
  logic [DATA_W-1:0] memRdata;

  modport slave (
    input  req0, we0, addr0, wdata0, dqm0,
    input  req1, we1, addr1, wdata1, dqm1, lock1,
    input  memRdata,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output memAddr, memWe, memWdata, memDQM
  );

  modport master (
    output req0, we0, addr0, wdata0, dqm0,
    output req1, we1, addr1, wdata1, dqm1, lock1,
    output memRdata,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  memAddr, memWe, memWdata, memDQM
  );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
// +-----------------------------------------------------------------------------+
// | rr_arb2 : 2-way round-robin grant with a one-bit priority pointer           |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic [1:0] req,
  input  wire logic       ptr_clr,
  output logic      [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (req[PORT_CORE] && (!req[PORT_DMA] || ptr == PORT_CORE)) begin
      gnt[PORT_CORE] = 1'b1;
    end else if (req[PORT_DMA]) begin
      gnt[PORT_DMA] = 1'b1;
    end
  end

  // The winner hands priority to the other port; idle cycles keep it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= PORT_CORE;
    end else if (ptr_clr) begin
      ptr <= PORT_CORE;
    end else if (gnt[PORT_CORE]) begin
      ptr <= other_port(PORT_CORE);
    end else if (gnt[PORT_DMA]) begin
      ptr <= other_port(PORT_DMA);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +-----------------------------------------------------------------------------+
// | mem_arbiter : core/DMA arbiter for one single-port synchronous memory       |
// | Optional bus lock for port 1 with `define ARB_LOCK_EN. Rev 1.0              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DQM_W  = DQM_WIDTH
) (
  input  wire logic     clk,
  input  wire logic     rst,
  mem_arbiter_if.slave  bus
);

  logic [1:0]        req_v;
  logic [1:0]        gnt_v;
  logic              lock_mask;
  logic              ptr_clr;
  logic              sel;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DQM_W-1:0]  sel_dqm;
  logic              rd_pend;
  logic              owner;
  logic              rsp_valid;

`ifdef ARB_LOCK_EN
  arb_state_t state;
  arb_state_t state_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RR;
    end else begin
      state <= state_nxt;
    end
  end

  // Port 0 is held off as soon as the loader asks for the lock, so the
  // loader's first access after the request already sits inside the lock.
  always_comb begin
    state_nxt = state;
    ptr_clr   = 1'b0;
    lock_mask = bus.lock1 || (state == LOCK1);
    case (state)
      RR: begin
        if (bus.lock1) state_nxt = LOCK1_PEND;
      end
      LOCK1_PEND: begin
        if (!bus.lock1) begin
          state_nxt = RR;
        end else if (gnt_v[PORT_DMA]) begin
          state_nxt = LOCK1;
        end
      end
      LOCK1: begin
        if (!bus.lock1) begin
          state_nxt = RR;
          ptr_clr   = 1'b1;
        end
      end
      default: state_nxt = RR;
    endcase
  end
`else
  logic unused_lock;
  assign unused_lock = bus.lock1;
  assign lock_mask   = 1'b0;
  assign ptr_clr     = 1'b0;
`endif

  assign req_v[PORT_CORE] = bus.req0 & ~rst & ~lock_mask;
  assign req_v[PORT_DMA]  = bus.req1 & ~rst;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .req     (req_v),
    .ptr_clr (ptr_clr),
    .gnt     (gnt_v)
  );

  assign bus.gnt0 = gnt_v[PORT_CORE];
  assign bus.gnt1 = gnt_v[PORT_DMA];

  always_comb begin
    sel       = gnt_v[PORT_DMA];
    sel_addr  = sel ? bus.addr1  : bus.addr0;
    sel_wdata = sel ? bus.wdata1 : bus.wdata0;
    sel_dqm   = sel ? bus.dqm1   : bus.dqm0;
  end

  assign bus.memAddr  = sel_addr;
  assign bus.memWdata = sel_wdata;
  assign bus.memDQM   = sel_dqm;
  assign bus.memWe    = (gnt_v[PORT_CORE] & bus.we0) | (gnt_v[PORT_DMA] & bus.we1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend <= 1'b0;
      owner   <= PORT_CORE;
    end else begin
      rd_pend <= (gnt_v[PORT_CORE] & ~bus.we0) | (gnt_v[PORT_DMA] & ~bus.we1);
      if (|gnt_v) owner <= gnt_v[PORT_DMA];
    end
  end

  // A read issued just before reset rises must not surface during reset.
  assign rsp_valid   = rd_pend & ~rst;
  assign bus.rvalid0 = rsp_valid & (owner == PORT_CORE);
  assign bus.rvalid1 = rsp_valid & (owner == PORT_DMA);
  assign bus.rdata0  = bus.rvalid0 ? bus.memRdata : '0;
  assign bus.rdata1  = bus.rvalid1 ? bus.memRdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// +-----------------------------------------------------------------------------+
// | tb_mem_arbiter : randomized scoreboard bench for mem_arbiter                |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_arbiter;

  typedef struct {
    logic [1:0]  gnt;
    logic [1:0]  rv;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  dqm;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .DQM_W(2)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .DQM_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Environment memory: synchronous, one-cycle read latency.
  logic [31:0] mem_arr [0:63];
  always @(posedge clk) begin
    if (bus.memWe) mem_arr[bus.memAddr[7:2]] <= bus.memWdata;
    bus.memRdata <= mem_arr[bus.memAddr[7:2]];
  end

  // Reference model state.
  logic [31:0] ref_mem [0:63];
  logic        fav;
  logic        pend [2];
  logic [31:0] pend_data [2];
  logic [1:0]  last_gnt;

  exp_t        exp_q [$];
  logic [31:0] rsp_q0 [$];
  logic [31:0] rsp_q1 [$];
  int          checks = 0;
  int          errors = 0;

  logic        s_rst;
  logic        s_req [2];
  logic        s_we [2];
  logic [31:0] s_addr [2];
  logic [31:0] s_wdata [2];
  logic [1:0]  s_dqm [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic set_req(input int k, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] dqm);
    s_req[k]   = 1'b1;
    s_we[k]    = we;
    s_addr[k]  = addr;
    s_wdata[k] = wdata;
    s_dqm[k]   = dqm;
  endtask

  task automatic clear_req();
    s_req[0] = 1'b0;
    s_req[1] = 1'b0;
  endtask

  task automatic drop_granted();
    for (int k = 0; k < 2; k++) if (last_gnt[k]) s_req[k] = 1'b0;
  endtask

  // Apply one cycle of stimulus, predict that cycle's behaviour, advance.
  task automatic step();
    exp_t e;
    int   w;
    rst        = s_rst;
    bus.req0   = s_req[0];  bus.we0 = s_we[0];  bus.addr0 = s_addr[0];
    bus.wdata0 = s_wdata[0]; bus.dqm0 = s_dqm[0];
    bus.req1   = s_req[1];  bus.we1 = s_we[1];  bus.addr1 = s_addr[1];
    bus.wdata1 = s_wdata[1]; bus.dqm1 = s_dqm[1];
    bus.lock1  = 1'b0;

    e.rv = s_rst ? 2'b00 : {pend[1], pend[0]};
    if (e.rv[0]) rsp_q0.push_back(pend_data[0]);
    if (e.rv[1]) rsp_q1.push_back(pend_data[1]);
    pend[0] = 1'b0; pend[1] = 1'b0;
    e.gnt = 2'b00; e.we = 1'b0; e.addr = '0; e.wdata = '0; e.dqm = '0;
    w = -1;
    if (s_rst) fav = 1'b0;
    else if (s_req[0] && s_req[1]) w = int'(fav);
    else if (s_req[0]) w = 0;
    else if (s_req[1]) w = 1;
    if (w >= 0) begin
      e.gnt[w] = 1'b1;
      fav      = (w == 0);
      e.we     = s_we[w];
      e.addr   = s_addr[w];
      e.wdata  = s_wdata[w];
      e.dqm    = s_dqm[w];
      if (s_we[w]) begin
        ref_mem[s_addr[w][7:2]] = s_wdata[w];
      end else begin
        pend[w]      = 1'b1;
        pend_data[w] = ref_mem[s_addr[w][7:2]];
      end
    end
    last_gnt = e.gnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gnt", 32'({bus.gnt1, bus.gnt0}), 32'(e.gnt));
      chk("memWe", 32'(bus.memWe), 32'(e.we));
      if (e.gnt != 2'b00) begin
        chk("memAddr", bus.memAddr, e.addr);
        chk("memDQM", 32'(bus.memDQM), 32'(e.dqm));
      end
      if (e.we) chk("memWdata", bus.memWdata, e.wdata);
      chk("rvalid", 32'({bus.rvalid1, bus.rvalid0}), 32'(e.rv));
      if (bus.rvalid0) begin
        if (rsp_q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp0_unexpected actual=rvalid0 required=no_response");
        end else begin
          chk("rdata0", bus.rdata0, rsp_q0.pop_front());
        end
      end else begin
        chk("rdata0_idle", bus.rdata0, 32'h0);
      end
      if (bus.rvalid1) begin
        if (rsp_q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp1_unexpected actual=rvalid1 required=no_response");
        end else begin
          chk("rdata1", bus.rdata1, rsp_q1.pop_front());
        end
      end else begin
        chk("rdata1_idle", bus.rdata1, 32'h0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = $urandom;
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    fav = 1'b0; pend[0] = 1'b0; pend[1] = 1'b0;
    pend_data[0] = '0; pend_data[1] = '0; last_gnt = 2'b00;
    for (int k = 0; k < 2; k++) begin
      s_req[k] = 1'b0; s_we[k] = 1'b0; s_addr[k] = '0; s_wdata[k] = '0; s_dqm[k] = '0;
    end
    s_rst = 1'b1;
    rst = 1'b1;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0; bus.dqm0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0; bus.dqm1 = '0;
    bus.lock1 = 1'b0;
    @(posedge clk);
    #1;

    // Reset with requests pending: no grants, no responses.
    set_req(0, 1'b0, 32'h0, 32'h0, 2'b10);
    set_req(1, 1'b1, 32'h4, 32'h1, 2'b10);
    step(); step();
    clear_req();
    s_rst = 1'b0;

    // Single port 0 read of 0x10.
    set_req(0, 1'b0, 32'h10, 32'h0, 2'b10);
    step(); drop_granted();
    step();

    // Both ports reading for four cycles from reset.
    s_rst = 1'b1; step(); s_rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      set_req(0, 1'b0, 32'(c) << 2, 32'h0, 2'b10);
      set_req(1, 1'b0, 32'(c + 8) << 2, 32'h0, 2'b10);
      step();
    end
    clear_req(); step();

    // Port 1 write vs port 0 read of the same word with pointer at 1.
    set_req(0, 1'b0, 32'h30, 32'h0, 2'b10);
    step(); clear_req();
    set_req(1, 1'b1, 32'h20, 32'h12345678, 2'b10);
    set_req(0, 1'b0, 32'h20, 32'h0, 2'b10);
    step(); drop_granted();
    step(); drop_granted();
    clear_req(); step();

    // Read granted, then reset the following cycle.
    set_req(0, 1'b0, 32'h40, 32'h0, 2'b10);
    step();
    s_rst = 1'b1; step(); step(); s_rst = 1'b0;
    set_req(1, 1'b0, 32'h44, 32'h0, 2'b01);
    step(); drop_granted();
    step(); clear_req(); step();

    // Idle for five cycles, then contend to observe the pointer.
    for (int c = 0; c < 5; c++) step();
    set_req(0, 1'b0, 32'h8, 32'h0, 2'b00);
    set_req(1, 1'b0, 32'hC, 32'h0, 2'b00);
    step(); drop_granted();
    step(); clear_req(); step();

    // Randomized traffic over a small address window to create hazards.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!s_req[k] && $urandom_range(0, 2) != 0) begin
          set_req(k, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2,
                  $urandom, 2'($urandom_range(0, 3)));
        end
      end
      step();
      drop_granted();
    end
    clear_req();
    step(); step();
    @(negedge clk);
    #1;
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    chk("rsp_q_drained", 32'(rsp_q0.size() + rsp_q1.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing one single-port synchronous data memory.
- Port 0 is the core load/store path: ALU result as address, store-formatted write data, DQM from control.
- Port 1 is a program loader/DMA path that fills and inspects memory.
- Per-cycle round-robin grant, one-cycle read latency, read responses routed back to the issuing requester.

Parameters:
ADDR_W, 32, address width on both requester ports and the memory port
DATA_W, 32, data width
DQM_W, 2, byte-mask/size code width, passed through unchanged

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req0  in  1  port 0 request, held until gnt0
we0  in  1  port 0 write (1) / read (0)
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
dqm0  in  DQM_W  port 0 mask/size code
gnt0  out  1  port 0 request accepted this cycle
rvalid0  out  1  port 0 read data valid
rdata0  out  DATA_W  port 0 read data
req1, we1, addr1, wdata1, dqm1, gnt1, rvalid1, rdata1  same as port 0, for port 1
lock1  in  1  port 1 bus lock request (used only with ARB_LOCK_EN)
memAddr  out  ADDR_W  memory address
memWe  out  1  memory write enable
memWdata  out  DATA_W  memory write data
memDQM  out  DQM_W  memory mask
memRdata  in  DATA_W  memory read data, valid one cycle after a read is issued

Behaviour:
- Reset state:
  - Priority pointer = 0 (port 0 favoured).
  - rvalid0 = rvalid1 = 0; owner register = 0.
  - gnt0 = gnt1 = 0 and memWe = 0 while rst is high.
  - memAddr, memWdata and memDQM are don't-care when no grant is active.
- Grant: combinational from the req inputs and the pointer register.
  - Exactly one gnt asserted when any req is high; never both.
  - Single requester: that requester is granted.
  - Both requesting: the port indicated by the pointer is granted.
- Pointer update: on any grant to port k, pointer <= 1-k at the next edge. No grant leaves the pointer unchanged.
- Memory drive: the mem* outputs mux the granted port's we/addr/wdata/dqm in the same cycle. memWe = gnt & we of the granted port.
- Read response:
  - A read granted in cycle N gives rvalidK = 1 in cycle N+1 only, for the issuing port.
  - rdataK = memRdata in that cycle; rdata of the other port is held at 0.
  - The owner register records the granted port at cycle N.
- Writes produce no response; gnt is the completion.
- Throughput: one transaction per cycle. Back-to-back reads from alternating ports give alternating rvalids.
- Handshake rule: a requester keeps req, we, addr, wdata and dqm stable until gnt. The arbiter does not check this.
- Reset mid-operation: an outstanding read issued the cycle before reset rises never produces rvalid.
- Simultaneous read on one port and write on the other: the winner is per the pointer. The loser waits at least one cycle; it is never dropped.

Optional Feature:
- Macro: ARB_LOCK_EN
- With the macro: a 3-state FSM with states RR, LOCK1_PEND and LOCK1.
  - RR -> LOCK1_PEND when lock1 rises.
  - LOCK1_PEND -> LOCK1 on the next grant to port 1.
  - In LOCK1, only port 1 is granted; req0 stalls.
  - LOCK1 -> RR when lock1 falls; the pointer is then set to 0.
  - Reset -> RR.
  - Purpose: atomic read-modify-write by the loader.
- Without the macro: lock1 is ignored, there is no FSM, and arbitration is pure round-robin.

Decomposition:
- Shared package holds:
  - The arbiter FSM state encoding: RR=2'd0, LOCK1_PEND=2'd1, LOCK1=2'd2.
  - The port index constants PORT_CORE=0 and PORT_DMA=1.
  - DQM width and encoding constants, shared with the control unit and data memory.
- One natural sub-module, rr_arb2: a 2-way round-robin grant with pointer register. The datapath mux and response routing stay in mem_arbiter.

Test Plan:
- Single port 0 read, addr=0x10, memory holds 0xDEADBEEF at 0x10:
  - gnt0 in the same cycle, memAddr=0x10.
  - Next cycle rvalid0=1 and rdata0=0xDEADBEEF; rvalid1=0.
- Both ports hold read requests for 4 cycles from reset:
  - Grant sequence 0,1,0,1.
  - rvalid alternates one cycle later with the correct per-port data.
- Port 1 write of 0x12345678 to 0x20 with dqm1=2'b10, concurrently with a port 0 read of 0x20, pointer at 1:
  - Write granted first.
  - Read granted the next cycle and returns 0x12345678.
- Read granted, then rst asserted the following cycle:
  - rvalid0 stays 0.
  - Pointer returns to 0.
  - gnt0 = gnt1 = 0 during reset.
- ARB_LOCK_EN, lock1 high with req1 and req0 both held for 3 cycles:
  - Only gnt1 is asserted throughout.
  - After lock1 drops, gnt0 is asserted on the next cycle.
- No requests for 5 cycles:
  - No gnt, no rvalid, memWe=0.
  - Pointer unchanged.
